// File: rtl/morse_capture_ctrl.sv
// morse_capture_ctrl: sequences a single Morse character-capture engine.
// Derives the dit/dah/word/tolerance thresholds from one base dit duration,
// kicks the capture engine with a start pulse, and queues every completed
// character or word gap into a small output FIFO for a downstream reader.

`ifndef PULSE_CNT_W
`define PULSE_CNT_W 16
`endif
`ifndef MORSE_LEN_W
`define MORSE_LEN_W 3
`endif
`ifndef MAX_MORSE_LEN
`define MAX_MORSE_LEN 6
`endif

module morse_capture_ctrl #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ce,
  input  logic                      enable,
  input  logic [`PULSE_CNT_W-1:0]   dit_time,
  output logic                      cap_start,
  output logic [`PULSE_CNT_W-1:0]   cap_dit_time,
  output logic [`PULSE_CNT_W-1:0]   cap_dah_time,
  output logic [`PULSE_CNT_W-1:0]   cap_word_time,
  output logic [`PULSE_CNT_W-1:0]   cap_tol_time,
  input  logic [`MORSE_LEN_W-1:0]   cap_len,
  input  logic [`MAX_MORSE_LEN-1:0] cap_dits_dahs,
  input  logic                      cap_error,
  input  logic                      cap_word_end,
  input  logic                      cap_ceo,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_space,
  output logic                      out_error,
  output logic [`MORSE_LEN_W-1:0]   out_len,
  output logic [`MAX_MORSE_LEN-1:0] out_dits_dahs,
  output logic                      busy,
  output logic                      overflow
);

  localparam int PW = `PULSE_CNT_W;
  localparam int LW = `MORSE_LEN_W;
  localparam int ML = `MAX_MORSE_LEN;
  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ARM    = 2'd2,
    LISTEN = 2'd3
  } state_t;

  typedef struct packed {
    logic          space;
    logic          error;
    logic [LW-1:0] len;
    logic [ML-1:0] dits_dahs;
  } entry_t;

  // Multiply the base duration by a small constant at PW+3 bits and clamp
  // to all-ones when the product no longer fits the threshold width.
  function automatic logic [PW-1:0] sat_mul(input logic [PW-1:0] base, input logic [2:0] k);
    logic [PW+2:0] prod;
    prod = {3'b000, base} * {{PW{1'b0}}, k};
    if (prod[PW+2:PW] != 3'b000) begin
      sat_mul = {PW{1'b1}};
    end else begin
      sat_mul = prod[PW-1:0];
    end
  endfunction

  state_t          state_r, state_next_s;
  logic            cap_start_r, busy_r, overflow_r;
  logic [PW-1:0]   dit_r, dah_r, word_r, tol_r;
  logic            push_s, pop_s, wr_en_s, empty_s, full_s;
  entry_t          push_entry_s, head_s;
  logic [AW:0]     wr_ptr_r, rd_ptr_r;
  entry_t          mem_r [FIFO_DEPTH];

  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign pop_s   = (~empty_s) & out_ready;
  assign wr_en_s = push_s & ((~full_s) | pop_s);
  assign head_s  = mem_r[rd_ptr_r[AW-1:0]];

  // Next-state and capture-event decode; nothing moves on ce=0 cycles.
  always_comb begin
    state_next_s = state_r;
    push_s       = 1'b0;
    push_entry_s = '0;
    if (ce) begin
      case (state_r)
        IDLE: begin
          if (enable) state_next_s = LOAD;
          else        state_next_s = IDLE;
        end
        LOAD: begin
          if (enable) state_next_s = ARM;
          else        state_next_s = IDLE;
        end
        ARM: begin
          if (enable) state_next_s = LISTEN;
          else        state_next_s = IDLE;
        end
        LISTEN: begin
          if (cap_ceo) begin
            push_s = 1'b1;
            if (cap_word_end) begin
              push_entry_s.space = 1'b1;
              if (enable) state_next_s = ARM;
              else        state_next_s = IDLE;
            end else begin
              push_entry_s.error     = cap_error;
              push_entry_s.len       = cap_len;
              push_entry_s.dits_dahs = cap_dits_dahs;
              state_next_s           = LISTEN;
            end
          end else if (!enable) begin
            state_next_s = IDLE;
          end else begin
            state_next_s = LISTEN;
          end
        end
        default: state_next_s = IDLE;
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // State register plus registered decodes of the upcoming state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cap_start_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      cap_start_r <= (state_next_s == ARM);
      busy_r      <= (state_next_s != IDLE);
    end
  end

  // Threshold registers: captured only while in LOAD on a ce cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dit_r  <= {PW{1'b0}};
      dah_r  <= {PW{1'b0}};
      word_r <= {PW{1'b0}};
      tol_r  <= {PW{1'b0}};
    end else if (ce && (state_r == LOAD)) begin
      dit_r  <= dit_time;
      dah_r  <= sat_mul(dit_time, 3'd3);
      word_r <= sat_mul(dit_time, 3'd7);
      tol_r  <= dit_time >> 1;
    end
  end

  // Sticky drop flag: set on a rejected push, cleared when a new run starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_r <= 1'b0;
    end else if (ce && (state_r == IDLE) && enable) begin
      overflow_r <= 1'b0;
    end else if (push_s && full_s && !pop_s) begin
      overflow_r <= 1'b1;
    end
  end

  // FIFO storage and pointers; pop is free-running, push is ce-qualified.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= push_entry_s;
        wr_ptr_r                <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Head-of-queue view, forced to zero whenever the queue is empty.
  always_comb begin
    out_valid = ~empty_s;
    if (empty_s) begin
      out_space     = 1'b0;
      out_error     = 1'b0;
      out_len       = {LW{1'b0}};
      out_dits_dahs = {ML{1'b0}};
    end else begin
      out_space     = head_s.space;
      out_error     = head_s.error;
      out_len       = head_s.len;
      out_dits_dahs = head_s.dits_dahs;
    end
  end

  assign cap_start     = cap_start_r;
  assign busy          = busy_r;
  assign overflow      = overflow_r;
  assign cap_dit_time  = dit_r;
  assign cap_dah_time  = dah_r;
  assign cap_word_time = word_r;
  assign cap_tol_time  = tol_r;

endmodule
